// File: rtl/pkg_rolhas.sv
// Shared definitions for the cork buffer sequencer.
// State encoding, default capacities and counter width.
package pkg_rolhas;

  localparam int W          = 7;
  localparam int MAX_ROLHAS = 99;
  localparam int MIN_PRI    = 5;
  localparam int LOTE       = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } estado_e;

endpackage

// File: rtl/modulo_escalonador_rolhas_if.sv
// Operator load handshake: level request with quantity,
// answered by a one-cycle ack or error pulse.
interface modulo_escalonador_rolhas_if #(
  parameter int W = pkg_rolhas::W
) ();

  logic         op_req;
  logic [W-1:0] op_qty;
  logic         op_ack;
  logic         op_err;

  modport master (
    output op_req,
    output op_qty,
    input  op_ack,
    input  op_err
  );

  modport slave (
    input  op_req,
    input  op_qty,
    output op_ack,
    output op_err
  );

endinterface

// File: rtl/modulo_contador_rolhas_sat.sv
// Occupancy counter: inc, dec and parallel add in one cycle,
// never decrementing below zero.
module modulo_contador_rolhas_sat #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc_i,
  input  logic         dec_i,
  input  logic [W-1:0] add_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic [W+1:0] sum;

  always_comb begin
    sum = {2'b00, cnt_q} + {2'b00, add_i}
        + (W+2)'(inc_i);
    cnt_d = sum[W-1:0];
    if (dec_i && (sum != '0)) begin
      cnt_d = W'(sum - (W+2)'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/modulo_escalonador_rolhas.sv
// Cork buffer sequencer: operator loads, secondary->principal refill
// and sealer consumption. ROLHAS_XFER_PARCIAL_EN enables partial refills.
module modulo_escalonador_rolhas
  import pkg_rolhas::*;
#(
  parameter int W          = pkg_rolhas::W,
  parameter int MAX_ROLHAS = pkg_rolhas::MAX_ROLHAS,
  parameter int MIN_PRI    = pkg_rolhas::MIN_PRI,
  parameter int LOTE       = pkg_rolhas::LOTE
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        ve_pulse,
  modulo_escalonador_rolhas_if.slave  op,
  output logic [W-1:0]                buf_sec,
  output logic [W-1:0]                buf_pri,
  output logic                        xfer_busy,
  output logic                        xfer_done,
  output logic                        ro,
  output logic [1:0]                  estado
);

  localparam logic [W-1:0] MAX_V  = W'(MAX_ROLHAS);
  localparam logic [W-1:0] MIN_V  = W'(MIN_PRI);
  localparam logic [W-1:0] LOTE_V = W'(LOTE);
  localparam logic [W-1:0] ONE_V  = W'(1);

  estado_e      estado_q;
  logic [W-1:0] rem_q;
  logic         ack_q;
  logic         err_q;
  logic         done_q;

  logic         cons;
  logic         move;
  logic         elig;
  logic         refill;
  logic [W:0]   sum_w;
  logic         load_ok;
  logic         acc;
  logic [W-1:0] add_sec;
  logic         fim;

  assign cons = ve_pulse && (buf_pri != '0);
  assign move = (estado_q == XFER);

`ifdef ROLHAS_XFER_PARCIAL_EN
  assign elig = (buf_sec != '0);
`else
  assign elig = (buf_sec >= LOTE_V);
`endif

  assign refill = (buf_pri < MIN_V) && elig;

  // Wide sum so an oversized offer cannot wrap into range
  assign sum_w   = {1'b0, buf_sec} + {1'b0, op.op_qty};
  assign load_ok = (op.op_qty != '0)
                && (sum_w <= {1'b0, MAX_V});
  assign acc     = (estado_q == LOAD)
                && op.op_req && load_ok;
  assign add_sec = acc ? op.op_qty : '0;

  // A move cancelled by consumption never fills the principal
  assign fim = (rem_q == ONE_V)
            || (buf_sec == ONE_V)
            || ((buf_pri + ONE_V == MAX_V) && !cons);

  always_ff @(posedge clk) begin
    if (!clr) begin
      estado_q <= IDLE;
      rem_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (estado_q)
        IDLE: begin
          if (refill) begin
            estado_q <= XFER;
            rem_q    <= LOTE_V;
          end else if (op.op_req) begin
            estado_q <= LOAD;
          end
        end
        LOAD: begin
          estado_q <= IDLE;
          ack_q    <= op.op_req && load_ok;
          err_q    <= op.op_req && !load_ok;
        end
        XFER: begin
          rem_q <= rem_q - ONE_V;
          if (fim) begin
            estado_q <= DONE;
            done_q   <= 1'b1;
          end
        end
        DONE: begin
          estado_q <= IDLE;
        end
        default: begin
          estado_q <= IDLE;
        end
      endcase
    end
  end

  modulo_contador_rolhas_sat #(
    .W (W)
  ) u_sec (
    .clk   (clk),
    .clr   (clr),
    .inc_i (1'b0),
    .dec_i (move),
    .add_i (add_sec),
    .cnt_o (buf_sec)
  );

  modulo_contador_rolhas_sat #(
    .W (W)
  ) u_pri (
    .clk   (clk),
    .clr   (clr),
    .inc_i (move),
    .dec_i (cons),
    .add_i ('0),
    .cnt_o (buf_pri)
  );

  assign op.op_ack = ack_q;
  assign op.op_err = err_q;
  assign xfer_busy = (estado_q == XFER);
  assign xfer_done = done_q;
  assign ro        = (buf_pri == '0);
  assign estado    = estado_q;

endmodule

// File: tb/tb_modulo_escalonador_rolhas.sv
// Bench for modulo_escalonador_rolhas: directed scenarios plus
// randomized traffic against a cycle model of the buffer rules.
module tb_modulo_escalonador_rolhas;

  localparam int MAXR = 99;
  localparam int MINP = 5;
  localparam int LOTE = 20;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       ve_pulse = 1'b0;
  logic [6:0] buf_sec;
  logic [6:0] buf_pri;
  logic       xfer_busy;
  logic       xfer_done;
  logic       ro;
  logic [1:0] estado;

  modulo_escalonador_rolhas_if #(.W(7)) ifc ();

  modulo_escalonador_rolhas dut (
    .clk       (clk),
    .clr       (clr),
    .ve_pulse  (ve_pulse),
    .op        (ifc),
    .buf_sec   (buf_sec),
    .buf_pri   (buf_pri),
    .xfer_busy (xfer_busy),
    .xfer_done (xfer_done),
    .ro        (ro),
    .estado    (estado)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d",
                  nm, act, exp);
  endtask

  // Reference: occupancy as plain integers, phase as spec code
  int m_sec = 0, m_pri = 0, m_ph = 0, m_rem = 0;
  bit m_ack = 0, m_err = 0, m_done = 0, m_live = 0;
  int cons_m, s_m, p_m;

  function automatic bit elig(input int s);
`ifdef ROLHAS_XFER_PARCIAL_EN
    return s > 0;
`else
    return s >= LOTE;
`endif
  endfunction

  always @(posedge clk) begin
    if (!clr) begin
      m_sec = 0; m_pri = 0; m_ph = 0; m_rem = 0;
      m_ack = 0; m_err = 0; m_done = 0; m_live = 1;
    end else begin
      s_m = m_sec;
      p_m = m_pri;
      cons_m = (ve_pulse && p_m > 0) ? 1 : 0;
      m_ack = 0; m_err = 0; m_done = 0;
      case (m_ph)
        0: begin
          m_pri = p_m - cons_m;
          if (p_m < MINP && elig(s_m)) begin
            m_ph = 2;
            m_rem = LOTE;
          end else if (ifc.op_req) m_ph = 1;
        end
        1: begin
          m_pri = p_m - cons_m;
          if (ifc.op_req) begin
            if (ifc.op_qty != 0 &&
                s_m + int'(ifc.op_qty) <= MAXR) begin
              m_sec = s_m + int'(ifc.op_qty);
              m_ack = 1;
            end else m_err = 1;
          end
          m_ph = 0;
        end
        2: begin
          m_sec = s_m - 1;
          m_pri = p_m + 1 - cons_m;
          m_rem = m_rem - 1;
          if (m_rem == 0 || m_sec == 0 ||
              (m_pri == MAXR && cons_m == 0)) begin
            m_ph = 3;
            m_done = 1;
          end
        end
        default: begin
          m_pri = p_m - cons_m;
          m_ph = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("estado", int'(estado), m_ph);
      chk("buf_sec", int'(buf_sec), m_sec);
      chk("buf_pri", int'(buf_pri), m_pri);
      chk("ro", int'(ro), int'(m_pri == 0));
      chk("xfer_busy", int'(xfer_busy), int'(m_ph == 2));
      chk("xfer_done", int'(xfer_done), int'(m_done));
      chk("op_ack", int'(ifc.op_ack), int'(m_ack));
      chk("op_err", int'(ifc.op_err), int'(m_err));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    ifc.op_req = 1'b0;
    ve_pulse = 1'b0;
    clr = 1'b0;
    cyc(2);
    clr = 1'b1;
  endtask

  task automatic do_load(input int q, output bit a,
                         output bit e);
    a = 0;
    e = 0;
    @(negedge clk);
    ifc.op_qty = 7'(q);
    ifc.op_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifc.op_ack || ifc.op_err) begin
        a = ifc.op_ack;
        e = ifc.op_err;
        ifc.op_req = 1'b0;
        return;
      end
    end
    ifc.op_req = 1'b0;
    chk("load_timeout", 0, 1);
  endtask

  task automatic wait_done(output int busy);
    busy = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (xfer_busy) busy++;
      if (xfer_done) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (xfer_busy) return;
    end
    chk("busy_timeout", 0, 1);
  endtask

  bit a, e;
  int b, p0, q;

  initial begin
    ifc.op_req = 1'b0;
    ifc.op_qty = '0;
    clr = 1'b0;
    cyc(3);
    chk("rst_estado", int'(estado), 0);
    chk("rst_sec", int'(buf_sec), 0);
    chk("rst_pri", int'(buf_pri), 0);
    chk("rst_ro", int'(ro), 1);
    chk("rst_busy", int'(xfer_busy), 0);
    clr = 1'b1;

    @(negedge clk); ve_pulse = 1'b1;
    @(negedge clk); ve_pulse = 1'b0;
    chk("empty_pri", int'(buf_pri), 0);
    chk("empty_ro", int'(ro), 1);

    do_load(40, a, e);
    chk("ld40_ack", int'(a), 1);
    chk("ld40_sec", int'(buf_sec), 40);
    wait_done(b);
    chk("x1_busy", b, 20);
    chk("x1_pri", int'(buf_pri), 20);
    chk("x1_sec", int'(buf_sec), 20);

    do_load(70, a, e);
    chk("ld70_sec", int'(buf_sec), 90);
    do_load(10, a, e);
    chk("ld10_err", int'(e), 1);
    chk("ld10_sec", int'(buf_sec), 90);
    do_load(9, a, e);
    chk("ld9_ack", int'(a), 1);
    chk("ld9_sec", int'(buf_sec), 99);
    do_load(0, a, e);
    chk("ld0_err", int'(e), 1);

    repeat (16) begin
      @(negedge clk);
      ve_pulse = 1'b1;
    end
    @(negedge clk);
    ve_pulse = 1'b0;
    wait_busy();
    p0 = int'(buf_pri);
    chk("x2_start", p0, 4);
    ve_pulse = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("x2_hold", int'(buf_pri), p0);
    end
    ve_pulse = 1'b0;
    wait_done(b);
    chk("x2_pri", int'(buf_pri), 19);
    chk("x2_sec", int'(buf_sec), 79);

    do_reset();
    do_load(7, a, e);
    chk("ld7_ack", int'(a), 1);
`ifdef ROLHAS_XFER_PARCIAL_EN
    wait_done(b);
    chk("part_busy", b, 7);
    chk("part_pri", int'(buf_pri), 7);
    chk("part_sec", int'(buf_sec), 0);
`else
    cyc(30);
    chk("nopart_busy", int'(xfer_busy), 0);
    chk("nopart_pri", int'(buf_pri), 0);
    chk("nopart_sec", int'(buf_sec), 7);
`endif

    do_reset();
    do_load(40, a, e);
    wait_busy();
    cyc(9);
    clr = 1'b0;
    @(negedge clk);
    chk("abort_estado", int'(estado), 0);
    chk("abort_sec", int'(buf_sec), 0);
    chk("abort_pri", int'(buf_pri), 0);
    chk("abort_ro", int'(ro), 1);
    chk("abort_busy", int'(xfer_busy), 0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_done", int'(xfer_done), 0);
      @(negedge clk);
    end
    clr = 1'b1;

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (ifc.op_req && (ifc.op_ack || ifc.op_err)) begin
        ifc.op_req = 1'b0;
      end else if (ifc.op_req &&
                   $urandom_range(0, 29) == 0) begin
        ifc.op_req = 1'b0;
      end else if (!ifc.op_req &&
                   $urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0: q = MAXR - m_sec;
          1: q = MAXR + 1 - m_sec;
          2: q = 0;
          default: q = int'($urandom_range(1, 40));
        endcase
        ifc.op_qty = 7'(q);
        ifc.op_req = 1'b1;
      end
      ve_pulse = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 599) != 0);
    end
    @(negedge clk);
    clr = 1'b1;
    ve_pulse = 1'b0;
    ifc.op_req = 1'b0;
    cyc(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
